// File: rtl/pipe_latch.sv
// Pipeline stage register with a valid/ready handshake, a one-entry skid buffer and a synchronous flush.
// The upstream ready depends only on registered state, so the handshake does not form a combinational path from out_ready back to in_ready.
module pipe_latch #(
  parameter int unsigned           WIDTH     = 16,
  parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  state_t           stateNext;
  logic [WIDTH-1:0] mainReg;
  logic [WIDTH-1:0] mainNext;
  logic [WIDTH-1:0] skidReg;
  logic [WIDTH-1:0] skidNext;
  logic             inFire;
  logic             outFire;

  assign in_ready  = rst_n & (state != FULL);
  assign out_valid = (state != EMPTY);
  assign out_data  = mainReg;
  assign inFire    = in_valid & in_ready;
  assign outFire   = out_valid & out_ready;

  always_comb begin
    occupancy = 2'd0;
    case (state)
      ONE:     occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  always_comb begin
    stateNext = state;
    mainNext  = mainReg;
    skidNext  = skidReg;
    case (state)
      EMPTY: begin
        if (inFire) begin
          mainNext  = in_data;
          stateNext = ONE;
        end
      end
      ONE: begin
        if (inFire && outFire) begin
          mainNext = in_data;
        end else if (inFire) begin
          skidNext  = in_data;
          stateNext = FULL;
        end else if (outFire) begin
          stateNext = EMPTY;
        end
      end
      FULL: begin
        if (outFire) begin
          mainNext  = skidReg;
          stateNext = ONE;
        end
      end
      default: stateNext = EMPTY;
    endcase
    // Flush squashes the entries but leaves both data registers untouched.
    if (flush) begin
      stateNext = EMPTY;
      mainNext  = mainReg;
      skidNext  = skidReg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= EMPTY;
      mainReg <= RESET_VAL;
      skidReg <= RESET_VAL;
    end else begin
      state   <= stateNext;
      mainReg <= mainNext;
      skidReg <= skidNext;
    end
  end

endmodule

// File: tb/tb_pipe_latch.sv
// Directed-stimulus bench for pipe_latch; a negedge monitor scoreboards every handshake against a queue model.
module tb_pipe_latch;

  localparam int unsigned      W    = 16;
  localparam logic [W-1:0]     RVAL = 16'h1234;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   occupancy;

  int unsigned checks = 0;
  int unsigned passes = 0;
  int unsigned pops   = 0;
  bit          started = 1'b0;
  logic [W-1:0] expQ[$];

  pipe_latch #(.WIDTH(W), .RESET_VAL(RVAL)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: state checks reflect the last edge; queue updates model the coming edge.
  logic [W-1:0] prevData;
  bit           prevStall = 1'b0;
  always @(negedge clk) begin
    if (started) begin
      check("mon_occupancy", 64'(occupancy), 64'(expQ.size()));
      check("mon_out_valid", 64'(out_valid), 64'(expQ.size() != 0));
      check("mon_in_ready", 64'(in_ready), 64'(rst_n && expQ.size() < 2));
      if (prevStall) check("mon_stable", 64'(out_data), 64'(prevData));
      prevStall = out_valid && !out_ready && rst_n && !flush;
      prevData  = out_data;
      if (!rst_n) begin
        expQ.delete();
      end else begin
        if (out_valid && out_ready) begin
          if (expQ.size() == 0) check("mon_unexpected_out", 64'(out_data), 64'hDEAD_0000);
          else check("mon_out_data", 64'(out_data), 64'(expQ.pop_front()));
          pops++;
        end
        if (flush) expQ.delete();
        else if (in_valid && in_ready) expQ.push_back(in_data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 16'hAAAA; out_ready = 1'b0;
    @(posedge clk);
    started = 1'b1;
    #1;
    step();
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'h1234);
    check("rst_occupancy", 64'(occupancy), 64'd0);
    rst_n = 1'b1; in_valid = 1'b0;
    #1 check("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Streaming
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = 16'(i);
      step();
      check("stream_data", 64'(out_data), 64'(i));
      check("stream_occ", 64'(occupancy), 64'd1);
    end
    in_valid = 1'b0;
    step();
    check("stream_drain_occ", 64'(occupancy), 64'd0);

    // Backpressure and stability
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h00A1; step();
    in_data = 16'h00A2; step();
    in_data = 16'h00A3;
    check("bp_occ", 64'(occupancy), 64'd2);
    check("bp_in_ready", 64'(in_ready), 64'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_data", 64'(out_data), 64'h00A1);
      check("stall_valid", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    step();
    check("bp_out2", 64'(out_data), 64'h00A2);
    step();
    check("bp_out3", 64'(out_data), 64'h00A3);
    in_valid = 1'b0;
    step();
    check("bp_drain_occ", 64'(occupancy), 64'd0);

    // Flush from FULL with a stalled 0xBEEF upstream
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h00B1; step();
    in_data = 16'h00B2; step();
    check("fl_full_occ", 64'(occupancy), 64'd2);
    flush = 1'b1; in_data = 16'hBEEF; step();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_occ", 64'(occupancy), 64'd0);
    check("fl_out_valid", 64'(out_valid), 64'd0);
    check("fl_in_ready", 64'(in_ready), 64'd1);
    check("fl_data_kept", 64'(out_data), 64'h00B1);

    // Flush from ONE discards a same-cycle accepted beat
    in_valid = 1'b1; in_data = 16'h00C1; step();
    flush = 1'b1; in_data = 16'h00C2; step();
    flush = 1'b0; in_valid = 1'b0;
    check("fl1_occ", 64'(occupancy), 64'd0);
    check("fl1_data_kept", 64'(out_data), 64'h00C1);

    // Reset wins over flush mid-operation
    in_valid = 1'b1; in_data = 16'h00D1; step();
    in_valid = 1'b0;
    check("rf_pre_occ", 64'(occupancy), 64'd1);
    rst_n = 1'b0; flush = 1'b1; step();
    rst_n = 1'b1; flush = 1'b0;
    check("rf_occ", 64'(occupancy), 64'd0);
    check("rf_out_valid", 64'(out_valid), 64'd0);
    check("rf_out_data", 64'(out_data), 64'h1234);
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 16'h0055; step();
    in_valid = 1'b0;
    check("rf_push_data", 64'(out_data), 64'h0055);
    step(); step();
    check("end_pops", 64'(pops), 64'd12);
    check("end_queue_empty", 64'(expQ.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
